// File: rtl/cpu_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Used by if_fetch_unit and next_pc_sel; see FETCH_ALIGN_CHECK_EN in if_fetch_unit.
package cpu_fetch_pkg;

   typedef enum logic [1:0] {
      S_REQ,
      S_WAIT,
      S_HOLD,
      S_DROP
   } fetch_state_t;

   typedef enum logic [2:0] {
      SRC_NONE,
      SRC_BRANCH,
      SRC_ILLOP,
      SRC_JR,
      SRC_JUMP,
      SRC_IRQ
   } redir_src_t;

   localparam logic [31:0] RESET_PC_DEFAULT  = 32'h8000_0000;
   localparam logic [31:0] ILLOP_VEC_DEFAULT = 32'h8000_0004;
   localparam logic [31:0] XADR_VEC_DEFAULT  = 32'h8000_0008;

   // The supervisor bit survives the increment; the low 31 bits wrap on their own.
   function automatic logic [31:0] pc_inc4(input logic [31:0] pc);
      return {pc[31], pc[30:0] + 31'd4};
   endfunction

endpackage

// File: rtl/if_fetch_unit_next_pc_sel.sv
// Combinational redirect priority: branch > illop > jr > jump > irq.
// With FETCH_ALIGN_CHECK_EN, a misaligned jr/branch/jump target becomes the illop vector.
module next_pc_sel
   import cpu_fetch_pkg::*;
#(
   parameter logic [31:0] ILLOP_VEC = ILLOP_VEC_DEFAULT,
   parameter logic [31:0] XADR_VEC  = XADR_VEC_DEFAULT
) (
   input  logic        i_pc_msb,
   input  logic        i_branch_taken,
   input  logic [31:0] i_branch_target,
   input  logic        i_exc_illop,
   input  logic        i_jr,
   input  logic [31:0] i_jr_target,
   input  logic        i_jump,
   input  logic [31:0] i_jump_target,
   input  logic        i_irq,
   output logic        o_redirect,
   output logic [31:0] o_target,
   output logic        o_irq_take
`ifdef FETCH_ALIGN_CHECK_EN
   ,
   output logic        o_align_fault,
   output logic [31:0] o_fault_addr
`endif
);

   redir_src_t  w_src;
   logic [31:0] w_raw_target;

   always_comb begin
      w_src        = SRC_NONE;
      w_raw_target = '0;
      if (i_branch_taken) begin
         w_src        = SRC_BRANCH;
         w_raw_target = i_branch_target;
      end else if (i_exc_illop) begin
         w_src        = SRC_ILLOP;
         w_raw_target = ILLOP_VEC;
      end else if (i_jr) begin
         w_src        = SRC_JR;
         w_raw_target = i_jr_target;
      end else if (i_jump) begin
         w_src        = SRC_JUMP;
         w_raw_target = i_jump_target;
      end else if (i_irq && !i_pc_msb) begin
         // Interrupts are masked while running in supervisor space.
         w_src        = SRC_IRQ;
         w_raw_target = XADR_VEC;
      end
   end

`ifdef FETCH_ALIGN_CHECK_EN
   logic w_misaligned;
   assign w_misaligned  = ((w_src == SRC_BRANCH) || (w_src == SRC_JR) || (w_src == SRC_JUMP))
                          && (w_raw_target[1:0] != 2'b00);
   assign o_align_fault = w_misaligned;
   assign o_fault_addr  = w_raw_target;
   assign o_target      = w_misaligned ? ILLOP_VEC : w_raw_target;
`else
   assign o_target      = w_raw_target;
`endif

   assign o_redirect = (w_src != SRC_NONE);
   assign o_irq_take = (w_src == SRC_IRQ);

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register, redirect handling and a single-outstanding
// request/ready handshake to instruction memory. Optional macro: FETCH_ALIGN_CHECK_EN.
module if_fetch_unit
   import cpu_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter logic [31:0] ILLOP_VEC = ILLOP_VEC_DEFAULT,
   parameter logic [31:0] XADR_VEC  = XADR_VEC_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        PC_Write,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        exc_illop,
   input  logic        jr,
   input  logic [31:0] jr_target,
   input  logic        jump,
   input  logic [31:0] jump_target,
   input  logic        irq,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr_out,
   output logic [31:0] pc_plus_4_out,
   output logic        fetch_valid,
   output logic        if_id_flush,
   output logic        irq_ack,
   output logic [31:0] epc_out
`ifdef FETCH_ALIGN_CHECK_EN
   ,
   output logic        align_fault
`endif
);

   fetch_state_t r_state;
   fetch_state_t w_state_next;
   logic [31:0]  r_pc;
   logic [31:0]  w_pc_next;
   logic [31:0]  r_hold_instr;
   logic [31:0]  w_hold_next;
   logic [31:0]  r_epc;
   logic [31:0]  w_epc_next;
   logic         w_redirect;
   logic [31:0]  w_target;
   logic         w_irq_take;
   logic         w_fetch_valid;
   logic [31:0]  w_instr;
`ifdef FETCH_ALIGN_CHECK_EN
   logic         w_align_fault;
   logic [31:0]  w_fault_addr;
`endif

   next_pc_sel #(
      .ILLOP_VEC (ILLOP_VEC),
      .XADR_VEC  (XADR_VEC)
   ) u_next_pc_sel (
      .i_pc_msb        (r_pc[31]),
      .i_branch_taken  (branch_taken),
      .i_branch_target (branch_target),
      .i_exc_illop     (exc_illop),
      .i_jr            (jr),
      .i_jr_target     (jr_target),
      .i_jump          (jump),
      .i_jump_target   (jump_target),
      .i_irq           (irq),
      .o_redirect      (w_redirect),
      .o_target        (w_target),
      .o_irq_take      (w_irq_take)
`ifdef FETCH_ALIGN_CHECK_EN
      ,
      .o_align_fault   (w_align_fault),
      .o_fault_addr    (w_fault_addr)
`endif
   );

   always_comb begin
      w_state_next  = r_state;
      w_pc_next     = r_pc;
      w_hold_next   = r_hold_instr;
      w_fetch_valid = 1'b0;
      w_instr       = '0;
      case (r_state)
         S_REQ: begin
            w_state_next = w_redirect ? S_DROP : S_WAIT;
         end
         S_WAIT: begin
            if (w_redirect) begin
               w_state_next = imem_ready ? S_REQ : S_DROP;
            end else if (imem_ready) begin
               w_fetch_valid = 1'b1;
               w_instr       = imem_rdata;
               if (PC_Write) begin
                  w_pc_next    = pc_inc4(r_pc);
                  w_state_next = S_REQ;
               end else begin
                  w_hold_next  = imem_rdata;
                  w_state_next = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (w_redirect) begin
               w_state_next = S_REQ;
            end else begin
               w_fetch_valid = 1'b1;
               w_instr       = r_hold_instr;
               if (PC_Write) begin
                  w_pc_next    = pc_inc4(r_pc);
                  w_state_next = S_REQ;
               end
            end
         end
         S_DROP: begin
            if (imem_ready) w_state_next = S_REQ;
         end
         default: w_state_next = S_REQ;
      endcase
      if (w_redirect) w_pc_next = w_target;
   end

   always_comb begin
      w_epc_next = r_epc;
      if (w_irq_take) w_epc_next = r_pc;
`ifdef FETCH_ALIGN_CHECK_EN
      if (w_align_fault) w_epc_next = w_fault_addr;
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= S_REQ;
         r_pc         <= RESET_PC;
         r_hold_instr <= '0;
         r_epc        <= '0;
      end else begin
         r_state      <= w_state_next;
         r_pc         <= w_pc_next;
         r_hold_instr <= w_hold_next;
         r_epc        <= w_epc_next;
      end
   end

   assign imem_req      = (r_state == S_REQ) && reset;
   assign imem_addr     = r_pc;
   assign pc_plus_4_out = pc_inc4(r_pc);
   assign fetch_valid   = w_fetch_valid;
   assign instr_out     = w_instr;
   assign if_id_flush   = w_redirect || (PC_Write && !w_fetch_valid);
   assign irq_ack       = w_irq_take && reset;
   assign epc_out       = r_epc;
`ifdef FETCH_ALIGN_CHECK_EN
   assign align_fault   = w_align_fault && reset;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios with literal expectations,
// then randomized traffic against a transaction-level reference model.
`timescale 1ns/1ps
module tb_if_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h8000_0000;
   localparam logic [31:0] ILLOP  = 32'h8000_0004;
   localparam logic [31:0] XADR   = 32'h8000_0008;

   logic        clk = 1'b0;
   logic        reset;
   logic        PC_Write;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        exc_illop;
   logic        jr;
   logic [31:0] jr_target;
   logic        jump;
   logic [31:0] jump_target;
   logic        irq;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] instr_out;
   logic [31:0] pc_plus_4_out;
   logic        fetch_valid;
   logic        if_id_flush;
   logic        irq_ack;
   logic [31:0] epc_out;
`ifdef FETCH_ALIGN_CHECK_EN
   logic        align_fault;
   logic        s_align;
`endif

   if_fetch_unit dut (
      .clk           (clk),
      .reset         (reset),
      .PC_Write      (PC_Write),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .exc_illop     (exc_illop),
      .jr            (jr),
      .jr_target     (jr_target),
      .jump          (jump),
      .jump_target   (jump_target),
      .irq           (irq),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ready    (imem_ready),
      .imem_rdata    (imem_rdata),
      .instr_out     (instr_out),
      .pc_plus_4_out (pc_plus_4_out),
      .fetch_valid   (fetch_valid),
      .if_id_flush   (if_id_flush),
      .irq_ack       (irq_ack),
`ifdef FETCH_ALIGN_CHECK_EN
      .align_fault   (align_fault),
`endif
      .epc_out       (epc_out)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: what the fetch stage owes the pipeline, in transaction terms.
   logic [31:0] m_pc, m_epc, m_held;
   bit          m_issue, m_inflight, m_stale, m_have;

   // Memory model with a single outstanding request.
   bit          mem_busy;
   int          mem_cnt;
   logic [31:0] mem_addr;
   int          lat_cfg;

   // Snapshots of the most recent checked cycle.
   logic        s_req, s_valid, s_flush, s_ack;
   logic [31:0] s_addr, s_instr, s_p4, s_epc;

   logic [31:0] req_log[$];
   logic [31:0] p4_log[$];

   function automatic logic [31:0] memword(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   function automatic logic [31:0] rand_tgt();
      int r;
      r = $urandom % 8;
      if (r == 0) return 32'hFFFF_FFFC;
      if (r == 1) return 32'h7FFF_FFFC;
      return 32'h0040_0000 | ($urandom & 32'h0000_0FFC) | (($urandom % 4 == 0) ? ($urandom & 32'h3) : 32'h0);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic clear_inputs();
      branch_taken = 0; exc_illop = 0; jr = 0; jump = 0; irq = 0;
      branch_target = '0; jr_target = '0; jump_target = '0;
   endtask

   task automatic run_cycle();
      logic        red, is_irq, afault;
      logic [31:0] tgt, bad, n_pc;
      logic        e_valid, e_flush;
      logic [31:0] e_instr;
      bit          n_inflight, n_have;
      @(negedge clk);
      red = 1; is_irq = 0; afault = 0; bad = '0;
      if (branch_taken)              tgt = branch_target;
      else if (exc_illop)            tgt = ILLOP;
      else if (jr)                   tgt = jr_target;
      else if (jump)                 tgt = jump_target;
      else if (irq && !m_pc[31]) begin tgt = XADR; is_irq = 1; end
      else begin red = 0; tgt = '0; end
`ifdef FETCH_ALIGN_CHECK_EN
      if (red && tgt[1:0] != 2'b00) begin afault = 1; bad = tgt; tgt = ILLOP; end
`endif
      e_valid = !red && (m_have || (m_inflight && !m_stale && imem_ready));
      e_instr = !e_valid ? 32'h0 : (m_have ? m_held : imem_rdata);
      e_flush = red || (PC_Write && !e_valid);

      chk("imem_req", imem_req, m_issue);
      chk("imem_addr", imem_addr, m_pc);
      chk("fetch_valid", fetch_valid, e_valid);
      chk("instr_out", instr_out, e_instr);
      chk("pc_plus_4_out", pc_plus_4_out, {m_pc[31], m_pc[30:0] + 31'd4});
      chk("if_id_flush", if_id_flush, e_flush);
      chk("irq_ack", irq_ack, is_irq);
      chk("epc_out", epc_out, m_epc);
`ifdef FETCH_ALIGN_CHECK_EN
      chk("align_fault", align_fault, afault);
      s_align = align_fault;
`endif
      s_req = imem_req; s_addr = imem_addr; s_valid = fetch_valid; s_instr = instr_out;
      s_p4 = pc_plus_4_out; s_flush = if_id_flush; s_ack = irq_ack; s_epc = epc_out;
      if (imem_req) req_log.push_back(imem_addr);
      if (fetch_valid) p4_log.push_back(pc_plus_4_out);

      if (m_issue) begin
         mem_busy = 1;
         mem_cnt  = (lat_cfg > 0) ? lat_cfg : int'($urandom_range(1, 4));
         mem_addr = m_pc;
      end

      n_pc = m_pc;
      if (e_valid && PC_Write) n_pc = {m_pc[31], m_pc[30:0] + 31'd4};
      if (red) n_pc = tgt;
      if (is_irq) m_epc = m_pc;
      if (afault) m_epc = bad;
      n_have = m_have;
      if (e_valid && !PC_Write && !m_have) begin n_have = 1; m_held = imem_rdata; end
      else if (m_have && (PC_Write || red)) n_have = 0;
      n_inflight = (m_inflight && !imem_ready) || m_issue;
      m_stale    = n_inflight && (m_stale || red);
      m_inflight = n_inflight;
      m_have     = n_have;
      m_issue    = !n_inflight && !n_have;
      m_pc       = n_pc;

      @(posedge clk);
      #1;
      imem_ready = 0;
      imem_rdata = $urandom;
      if (mem_busy) begin
         mem_cnt--;
         if (mem_cnt == 0) begin
            imem_ready = 1;
            imem_rdata = memword(mem_addr);
            mem_busy   = 0;
         end
      end
   endtask

   task automatic wait_req(output int n, output logic [31:0] addr);
      n = 0;
      do begin
         run_cycle();
         n++;
      end while (!s_req && n < 20);
      chk("req_timeout", s_req, 1'b1);
      addr = s_addr;
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2;
      reset = 0;
      clear_inputs();
      PC_Write = 0;
      #1;
      chk("rst_imem_req", imem_req, 1'b0);
      chk("rst_imem_addr", imem_addr, RST_PC);
      chk("rst_fetch_valid", fetch_valid, 1'b0);
      chk("rst_instr_out", instr_out, 32'h0);
      chk("rst_irq_ack", irq_ack, 1'b0);
      chk("rst_epc_out", epc_out, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      imem_ready = 0; imem_rdata = '0; mem_busy = 0; mem_cnt = 0;
      m_pc = RST_PC; m_epc = '0; m_held = '0;
      m_issue = 1; m_inflight = 0; m_stale = 0; m_have = 0;
      reset = 1;
   endtask

   task automatic random_cycles(input int n);
      lat_cfg = 0;
      for (int i = 0; i < n; i++) begin
         PC_Write      = ($urandom % 10) < 7;
         branch_taken  = ($urandom % 25) == 0;
         exc_illop     = ($urandom % 30) == 0;
         jr            = ($urandom % 25) == 0;
         jump          = ($urandom % 20) == 0;
         irq           = ($urandom % 15) == 0;
         branch_target = rand_tgt();
         jr_target     = rand_tgt();
         jump_target   = rand_tgt();
         run_cycle();
      end
      clear_inputs();
   endtask

   initial begin
      int          n, cnt_v, cnt_r;
      logic [31:0] a;
      logic [31:0] wrap_tgt[2];
      logic [31:0] wrap_p4[2];
      reset = 0;
      clear_inputs();
      PC_Write = 0; imem_ready = 0; imem_rdata = '0; lat_cfg = 1;
      do_reset();

      // Straight-line fetch with 1-cycle memory.
      PC_Write = 1;
      req_log.delete(); p4_log.delete();
      repeat (6) run_cycle();
      chk("seq_req_count", req_log.size(), 3);
      chk("seq_p4_count", p4_log.size(), 3);
      if (req_log.size() == 3 && p4_log.size() == 3) begin
         chk("seq_addr0", req_log[0], 32'h8000_0000);
         chk("seq_addr1", req_log[1], 32'h8000_0004);
         chk("seq_addr2", req_log[2], 32'h8000_0008);
         chk("seq_p4_0", p4_log[0], 32'h8000_0004);
         chk("seq_p4_1", p4_log[1], 32'h8000_0008);
      end

      // Stall while the response lands: word is held, no flush, no new request.
      PC_Write = 0;
      cnt_v = 0; cnt_r = 0;
      for (int i = 0; i < 5; i++) begin
         run_cycle();
         if (s_valid && !s_flush && s_instr == memword(32'h8000_000C)) cnt_v++;
         if (s_req) cnt_r++;
      end
      chk("hold_valid_cycles", cnt_v, 4);
      chk("hold_req_count", cnt_r, 1);
      PC_Write = 1;
      run_cycle();
      chk("hold_release_valid", s_valid, 1'b1);
      chk("hold_release_instr", s_instr, memword(32'h8000_000C));

      // Branch beats jump while waiting; the stale word never surfaces.
      lat_cfg = 2;
      run_cycle();
      chk("pre_branch_addr", s_addr, 32'h8000_0010);
      branch_taken = 1; branch_target = 32'h0040_0100;
      jump = 1; jump_target = 32'h0040_0020;
      run_cycle();
      chk("branch_flush", s_flush, 1'b1);
      clear_inputs();
      run_cycle();
      chk("stale_not_valid", s_valid, 1'b0);

      // Redirect in the request cycle, then an interrupt while draining.
      lat_cfg = 4;
      jump = 1; jump_target = 32'h0040_0010;
      run_cycle();
      chk("branch_fetch_addr", s_addr, 32'h0040_0100);
      clear_inputs();
      irq = 1;
      run_cycle();
      chk("irq_ack_pulse", s_ack, 1'b1);
      irq = 0;
      run_cycle();
      chk("irq_epc", s_epc, 32'h0040_0010);
      wait_req(n, a);
      chk("drop_cycles", n, 3);
      chk("irq_vector_addr", a, 32'h8000_0008);

      // Supervisor-space PC masks irq.
      lat_cfg = 1;
      irq = 1;
      cnt_v = 0;
      repeat (6) begin
         run_cycle();
         if (s_ack) cnt_v++;
      end
      chk("irq_masked_acks", cnt_v, 0);
      irq = 0;

      // Misaligned register jump.
      jr = 1; jr_target = 32'h0040_0006;
      run_cycle();
`ifdef FETCH_ALIGN_CHECK_EN
      chk("align_fault_pulse", s_align, 1'b1);
`endif
      clear_inputs();
      wait_req(n, a);
`ifdef FETCH_ALIGN_CHECK_EN
      chk("align_redirect_addr", a, 32'h8000_0004);
      chk("align_epc", s_epc, 32'h0040_0006);
`else
      chk("jr_plain_addr", a, 32'h0040_0006);
      chk("jr_epc_kept", s_epc, 32'h0040_0010);
`endif

      // PC+4 wraps within bits [30:0] and keeps bit 31.
      wrap_tgt[0] = 32'h7FFF_FFFC; wrap_p4[0] = 32'h0000_0000;
      wrap_tgt[1] = 32'hFFFF_FFFC; wrap_p4[1] = 32'h8000_0000;
      for (int k = 0; k < 2; k++) begin
         branch_taken = 1; branch_target = wrap_tgt[k];
         run_cycle();
         clear_inputs();
         wait_req(n, a);
         chk("wrap_addr", a, wrap_tgt[k]);
         chk("wrap_p4", s_p4, wrap_p4[k]);
      end

      random_cycles(1500);
      do_reset();
      random_cycles(500);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register.
- Owns the PC register and the next-PC priority select.
- Drives a request/ready handshake to a variable-latency instruction memory.
- Delivers instruction and PC+4 to IF/ID, plus an IF/ID flush request whenever IF/ID must load a bubble.

Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded on reset (supervisor bit PC[31]=1).
- ILLOP_VEC, 32'h8000_0004, illegal-instruction handler address.
- XADR_VEC, 32'h8000_0008, interrupt handler address.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- PC_Write  in  1  hazard unit: 1 = stage may advance, 0 = stall
- branch_taken  in  1  EX-stage branch resolved taken
- branch_target  in  32  branch destination
- exc_illop  in  1  ID-stage illegal opcode
- jr  in  1  ID-stage register jump
- jr_target  in  32  register jump destination
- jump  in  1  ID-stage J/JAL
- jump_target  in  32  J/JAL destination
- irq  in  1  external interrupt, level
- imem_req  out  1  memory request strobe
- imem_addr  out  32  request address
- imem_ready  in  1  one-cycle response pulse
- imem_rdata  in  32  response data, valid with imem_ready
- instr_out  out  32  instruction to IF/ID
- pc_plus_4_out  out  32  PC+4 to IF/ID
- fetch_valid  out  1  instr_out is a real instruction
- if_id_flush  out  1  IF/ID loads a bubble
- irq_ack  out  1  one-cycle pulse when the interrupt redirect is taken
- epc_out  out  32  return PC captured at irq_ack

Behaviour:
- Reset values: pc=RESET_PC, state=S_REQ, hold_instr=0, epc_out=0.
- Reset values, outputs: irq_ack=0, fetch_valid=0, instr_out=0; imem_req forced 0 while reset is low.
- Redirect priority: branch_taken > exc_illop > jr > jump > irq.
  - irq is accepted only when pc[31]=0 and no other redirect is active.
  - redirect = any accepted source. target = the winning source's address, ILLOP_VEC for exc_illop, XADR_VEC for irq.
- Redirects act regardless of PC_Write.
- pc_plus_4_out = {pc[31], pc[30:0]+4}. Bit 31 is preserved; bits [30:0] wrap modulo 2^31.
- imem_addr = pc at all times. imem_req=1 only in S_REQ.
- Responses: at most one outstanding request; imem_ready arrives ≥1 cycle after the request.
- State S_REQ:
  - Issue the request, then go to S_WAIT.
  - If redirect this cycle: pc<=target, go to S_DROP.
- State S_WAIT, imem_ready with no redirect:
  - fetch_valid=1, instr_out=imem_rdata.
  - If PC_Write: pc<=pc+4, go to S_REQ.
  - Otherwise: hold_instr<=imem_rdata, go to S_HOLD.
- State S_WAIT, redirect:
  - Returning data is discarded; pc<=target.
  - Go to S_REQ if imem_ready is present this cycle, else S_DROP.
- State S_HOLD:
  - fetch_valid=1, instr_out=hold_instr.
  - PC_Write: pc<=pc+4, go to S_REQ.
  - Redirect: pc<=target, go to S_REQ (held word dropped).
- State S_DROP: wait for imem_ready, discard the data, go to S_REQ. Further redirects here update pc only.
- Output outside valid cycles: instr_out=0 whenever fetch_valid=0.
- if_id_flush = redirect | (PC_Write & ~fetch_valid).
  - It never asserts on a plain stall, so the ID instruction is preserved.
- Interrupt: on irq acceptance, irq_ack=1 for that cycle and epc_out<=pc (the unfetched or discarded address).
- Reset mid-fetch: the state machine returns to S_REQ and the outstanding response is ignored. Memory must tolerate an abandoned request.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- When defined, a jr/branch/jump target with bits [1:0]≠0 is replaced by ILLOP_VEC.
  - Extra output align_fault pulses 1 cycle and epc_out<=offending target.
- When undefined, targets are used unchanged, align_fault does not exist, and irq/illop behaviour is identical.

Decomposition:
- Package cpu_fetch_pkg holds:
  - state enum S_REQ/S_WAIT/S_HOLD/S_DROP;
  - default vector constants RESET_PC, ILLOP_VEC, XADR_VEC;
  - redirect-source encoding.
- Sub-module next_pc_sel: purely combinational priority select producing redirect, target and irq_take.

Test Plan:
- Release reset with 1-cycle-latency memory returning PC-tagged data → imem_addr sequence 80000000, 80000004, 80000008; fetch_valid pulses; pc_plus_4_out 80000004, 80000008.
- Response arrives while PC_Write=0 for 3 cycles → S_HOLD; instr_out stable, if_id_flush=0, no new imem_req; advances on PC_Write=1.
- jump(0x00400020) and branch_taken(0x00400100) asserted together in S_WAIT → if_id_flush=1, next imem_addr=00400100, returned stale word never shows fetch_valid.
- irq=1 with pc=00400010 → irq_ack pulse, epc_out=00400010, next fetch 80000008. irq=1 with pc[31]=1 → ignored.
- Redirect in S_REQ with 4-cycle memory latency → S_DROP; exactly one request issued for the new target after the stale response.
- FETCH_ALIGN_CHECK_EN defined, jr_target=00400006 → align_fault=1, next fetch 80000004.
